mips_iter_divider: RTL and testbench



---
 rtl/mips_iter_divider.sv | 143 ++++++++++++++
 tb/tb_mips_iter_divider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient -> LO, remainder -> HI.
// Optional `DIV_ABORT_EN adds an abort input that cancels an in-flight operation.
module mips_iter_divider #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q, rem_step;
  logic [WIDTH-1:0] work_q, work_step;
  logic [WIDTH-1:0] div_q;
  logic             q_neg_q, r_neg_q, dz_q;

  logic             abort_req;
  logic             launch;
  logic             finish;
  logic             sign_a, sign_b, divisor_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef DIV_ABORT_EN
  assign abort_req = abort && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign sign_a       = is_signed & dividend[WIDTH-1];
  assign sign_b       = is_signed & divisor[WIDTH-1];
  assign mag_a        = sign_a ? (~dividend + ONE) : dividend;
  assign mag_b        = sign_b ? (~divisor + ONE) : divisor;
  assign divisor_zero = (divisor == '0);

  assign launch = (state_q == S_IDLE) && start;
  assign finish = (state_q == S_FINISH) && !abort_req;
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = divisor_zero ? S_FINISH : S_RUN;
      S_RUN:    if (cnt_q == CW'(1)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  // Retire BITS_PER_CYCLE quotient bits, MSB first; work_q shifts the
  // dividend out at the top and the quotient in at the bottom.
  always_comb begin
    rem_step  = rem_q;
    work_step = work_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_step  = {rem_step[WIDTH-1:0], work_step[WIDTH-1]};
      work_step = {work_step[WIDTH-2:0], 1'b0};
      if (rem_step >= {1'b0, div_q}) begin
        rem_step     = rem_step - {1'b0, div_q};
        work_step[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      div_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (launch) begin
      // On divide-by-zero work_q keeps the raw dividend for the HI result.
      work_q  <= divisor_zero ? dividend : mag_a;
      div_q   <= mag_b;
      rem_q   <= '0;
      cnt_q   <= divisor_zero ? '0 : CW'(N);
      q_neg_q <= sign_a ^ sign_b;
      r_neg_q <= sign_a;
      dz_q    <= divisor_zero;
    end else if (abort_req) begin
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      work_q <= work_step;
      rem_q  <= rem_step;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        if (dz_q) begin
          quotient    <= '1;
          remainder   <= work_q;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= q_neg_q ? (~work_q + ONE) : work_q;
          remainder   <= r_neg_q ? (~rem_q[WIDTH-1:0] + ONE) : rem_q[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_iter_divider.sv
// Scoreboard bench for mips_iter_divider: 32/1 main instance plus a 16/4 instance.
module tb_mips_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start = 1'b0, is_s = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dz;
  logic [31:0] q, r;

  logic        start16 = 1'b0, is_s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;

`ifdef DIV_ABORT_EN
  logic abort = 1'b0;
  logic abort16 = 1'b0;
`endif

  mips_iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(rst),
`ifdef DIV_ABORT_EN
    .abort(abort),
`endif
    .start(start), .is_signed(is_s), .dividend(a), .divisor(b),
    .busy(busy), .done(done), .quotient(q), .remainder(r), .div_by_zero(dz)
  );

  mips_iter_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .reset(rst),
`ifdef DIV_ABORT_EN
    .abort(abort16),
`endif
    .start(start16), .is_signed(is_s16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dz16)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.lat = (y == 0) ? 1 : 33;
    if (y == 0) begin
      e.q = '1; e.r = x; e.dz = 1'b1;
    end else if (!s) begin
      e.q = x / y; e.r = x % y; e.dz = 1'b0;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = '0; e.dz = 1'b0;
    end else begin
      e.q = $signed(x) / $signed(y); e.r = $signed(x) % $signed(y); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; is_s = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic collect(output logic [31:0] oq, output logic [31:0] orm, output logic odz,
                         output int lat, output logic busy_ok, output logic busy_at_done);
    lat = -1; busy_ok = 1'b1; busy_at_done = 1'b0; oq = '0; orm = '0; odz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; busy_at_done = busy; oq = q; orm = r; odz = dz;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total += 5;
    if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    if (q !== 32'h0)    begin bad++; $display("FAIL reset_quotient: got %h expected 0", q); end
    if (r !== 32'h0)    begin bad++; $display("FAIL reset_remainder: got %h expected 0", r); end
    if (dz !== 1'b0)    begin bad++; $display("FAIL reset_dz: got %b expected 0", dz); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_vectors();
    vec_t tbl[$];
    logic [31:0] oq, orm; logic odz, bok, bad_b; int lat; exp_t e;
    tbl.push_back('{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 33});
    tbl.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33});
    tbl.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 33});
    tbl.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33});
    tbl.push_back('{1'b0, 32'hFE8B_ACDE,  32'hFFFF_EDCA, 32'd0,        32'hFE8B_ACDE, 1'b0, 33});
    tbl.push_back('{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1});
    tbl.push_back('{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1});
    tbl.push_back('{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1});
    tbl.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 33});
    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat});
      issue(tbl[i].s, tbl[i].a, tbl[i].b);
      collect(oq, orm, odz, lat, bok, bad_b);
      e = sb.pop_front();
      total += 6;
      if (lat !== e.lat) begin bad++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      if (oq !== e.q)    begin bad++; $display("FAIL vec%0d_quotient: got %h expected %h", i, oq, e.q); end
      if (orm !== e.r)   begin bad++; $display("FAIL vec%0d_remainder: got %h expected %h", i, orm, e.r); end
      if (odz !== e.dz)  begin bad++; $display("FAIL vec%0d_dz: got %b expected %b", i, odz, e.dz); end
      if (bok !== 1'b1)  begin bad++; $display("FAIL vec%0d_busy_during: got %b expected 1", i, bok); end
      if (bad_b !== 1'b0) begin bad++; $display("FAIL vec%0d_busy_at_done: got %b expected 0", i, bad_b); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] oq, orm; logic odz, bok, bad_b; int lat; int extra; exp_t e;
    sb.push_back('{32'd142, 32'd6, 1'b0, 33});
    issue(1'b0, 32'd1000, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); start = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    collect(oq, orm, odz, lat, bok, bad_b);
    e = sb.pop_front();
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total += 5;
    if (lat + 6 !== e.lat) begin bad++; $display("FAIL ignore_latency: got %0d expected %0d", lat + 6, e.lat); end
    if (oq !== e.q)   begin bad++; $display("FAIL ignore_quotient: got %h expected %h", oq, e.q); end
    if (orm !== e.r)  begin bad++; $display("FAIL ignore_remainder: got %h expected %h", orm, e.r); end
    if (bok !== 1'b1) begin bad++; $display("FAIL ignore_busy: got %b expected 1", bok); end
    if (extra !== 0)  begin bad++; $display("FAIL ignore_no_relaunch: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oq, orm; logic odz, bok, bad_b; int lat; exp_t e;
    sb.push_back('{32'd142, 32'd6, 1'b0, 33});
    sb.push_back('{32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34});
    @(negedge clk); start = 1'b1; is_s = 1'b0; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    is_s = 1'b1; a = 32'hFFFF_FF9C; b = 32'd7;
    for (int n = 0; n < 2; n++) begin
      collect(oq, orm, odz, lat, bok, bad_b);
      if (n == 1) start = 1'b0;
      e = sb.pop_front();
      total += 4;
      if (lat !== e.lat) begin bad++; $display("FAIL b2b%0d_latency: got %0d expected %0d", n, lat, e.lat); end
      if (oq !== e.q)    begin bad++; $display("FAIL b2b%0d_quotient: got %h expected %h", n, oq, e.q); end
      if (orm !== e.r)   begin bad++; $display("FAIL b2b%0d_remainder: got %h expected %h", n, orm, e.r); end
      if (bad_b !== 1'b0) begin bad++; $display("FAIL b2b%0d_busy_at_done: got %b expected 0", n, bad_b); end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] oq, orm, x, y; logic odz, bok, bad_b, s; int lat; exp_t e;
    for (int i = 0; i < 14; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = $urandom;
        1:       y = $urandom_range(1, 255);
        2:       y = 32'd0;
        3:       y = -$urandom_range(1, 1000);
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      sb.push_back(model(s, x, y));
      issue(s, x, y);
      collect(oq, orm, odz, lat, bok, bad_b);
      e = sb.pop_front();
      total += 4;
      if (lat !== e.lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      if (oq !== e.q)    begin bad++; $display("FAIL rnd%0d_quotient %h/%h s=%b: got %h expected %h", i, x, y, s, oq, e.q); end
      if (orm !== e.r)   begin bad++; $display("FAIL rnd%0d_remainder %h/%h s=%b: got %h expected %h", i, x, y, s, orm, e.r); end
      if (odz !== e.dz)  begin bad++; $display("FAIL rnd%0d_dz: got %b expected %b", i, odz, e.dz); end
    end
  endtask

  task automatic test_width16();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{1'b0, 32'h0000_FFFF, 32'h0000_0010, 32'h0000_0FFF, 32'h0000_000F, 1'b0, 5});
    tbl.push_back('{1'b1, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0, 5});
    tbl.push_back('{1'b1, 32'h0000_FFF9, 32'h0000_0002, 32'h0000_FFFD, 32'h0000_FFFF, 1'b0, 5});
    tbl.push_back('{1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_1234, 1'b1, 1});
    foreach (tbl[i]) begin
      @(negedge clk);
      start16 = 1'b1; is_s16 = tbl[i].s; a16 = tbl[i].a[15:0]; b16 = tbl[i].b[15:0];
      @(posedge clk); #1; start16 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (done16) begin lat = k; break; end
      end
      total += 4;
      if (lat !== tbl[i].lat)       begin bad++; $display("FAIL w16_%0d_latency: got %0d expected %0d", i, lat, tbl[i].lat); end
      if (q16 !== tbl[i].q[15:0])   begin bad++; $display("FAIL w16_%0d_quotient: got %h expected %h", i, q16, tbl[i].q[15:0]); end
      if (r16 !== tbl[i].r[15:0])   begin bad++; $display("FAIL w16_%0d_remainder: got %h expected %h", i, r16, tbl[i].r[15:0]); end
      if (dz16 !== tbl[i].dz)       begin bad++; $display("FAIL w16_%0d_dz: got %b expected %b", i, dz16, tbl[i].dz); end
    end
  endtask

`ifdef DIV_ABORT_EN
  task automatic test_abort();
    logic [31:0] oq, orm; logic odz, bok, bad_b; int lat; int stray;
    issue(1'b0, 32'd100, 32'd7);
    collect(oq, orm, odz, lat, bok, bad_b);
    issue(1'b0, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    total += 5;
    if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin bad++; $display("FAIL abort_done: got %b expected 0", done); end
    if (q !== 32'd14)    begin bad++; $display("FAIL abort_held_quotient: got %h expected %h", q, 32'd14); end
    if (r !== 32'd2)     begin bad++; $display("FAIL abort_held_remainder: got %h expected %h", r, 32'd2); end
    if (dz !== 1'b0)     begin bad++; $display("FAIL abort_held_dz: got %b expected 0", dz); end
    stray = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) stray++; end
    sb.push_back('{32'd333, 32'd1, 1'b0, 33});
    issue(1'b0, 32'd1000, 32'd3);
    collect(oq, orm, odz, lat, bok, bad_b);
    total += 4;
    if (stray !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", stray); end
    if (lat !== sb[0].lat) begin bad++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, sb[0].lat); end
    if (oq !== sb[0].q)    begin bad++; $display("FAIL abort_restart_quotient: got %h expected %h", oq, sb[0].q); end
    if (orm !== sb[0].r)   begin bad++; $display("FAIL abort_restart_remainder: got %h expected %h", orm, sb[0].r); end
    void'(sb.pop_front());
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] oq, orm; logic odz, bok, bad_b; int lat; int stray;
    issue(1'b0, 32'd100, 32'd7);
    collect(oq, orm, odz, lat, bok, bad_b);
    total += 1;
    if (oq !== 32'd14) begin bad++; $display("FAIL rstmid_pre_quotient: got %h expected %h", oq, 32'd14); end
    issue(1'b0, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b expected 0", done); end
    if (q !== 32'h0)   begin bad++; $display("FAIL rstmid_quotient: got %h expected 0", q); end
    if (r !== 32'h0)   begin bad++; $display("FAIL rstmid_remainder: got %h expected 0", r); end
    if (dz !== 1'b0)   begin bad++; $display("FAIL rstmid_dz: got %b expected 0", dz); end
    @(negedge clk); rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done || busy) stray++; end
    total += 1;
    if (stray !== 0) begin bad++; $display("FAIL rstmid_stays_idle: got %0d active cycles expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_width16();
`ifdef DIV_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
